ex_flags_stage: RTL and testbench

Execute-to-memory boundary stage placed directly downstream of the 64-bit bit-slice ALU. Captures the ALU result and its zero/negative/carry/overflow outputs, and holds the architectural NZCV flag register, written only by flag-setting instructions. Evaluates conditional-branch outcomes (B.cond, CBZ, CBNZ) and registers result, destination and branch decision into the EX/MEM pipeline slot, with stall and flush handling.

---
 rtl/ex_flags_stage.sv | 108 ++++++++++
 tb/tb_ex_flags_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_flags_stage.sv
// EX/MEM boundary stage: registers the ALU result, holds the NZCV flag register and resolves
// B.cond/CBZ/CBNZ. Define ARM_COND_FULL_EN to evaluate all sixteen ARM condition codes.
module ex_flags_stage #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned REG_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] alu_out,
   input  logic              alu_zero,
   input  logic              alu_negative,
   input  logic              alu_carry,
   input  logic              alu_overflow,
   input  logic              set_flags,
   input  logic              is_bcond,
   input  logic              is_cbz,
   input  logic              is_cbnz,
   input  logic [3:0]        cond,
   input  logic [REG_W-1:0]  rd,
   input  logic              reg_write,
   output logic              mem_valid,
   output logic [DATA_W-1:0] mem_result,
   output logic [REG_W-1:0]  mem_rd,
   output logic              mem_reg_write,
   output logic              mem_branch_taken,
   output logic              flag_n,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_v
);

   logic cond_pass_c;
   logic taken_c;
   logic accept_c;

   // Condition evaluation always uses the committed flags, so a flag setter
   // and a B.cond in the same instruction sees the old NZCV.
   always_comb begin
      cond_pass_c = 1'b0;
      case (cond)
         4'b0000: cond_pass_c = flag_z;
         4'b0001: cond_pass_c = ~flag_z;
         4'b1010: cond_pass_c = (flag_n == flag_v);
         4'b1011: cond_pass_c = (flag_n != flag_v);
         4'b1110: cond_pass_c = 1'b1;
         4'b1111: cond_pass_c = 1'b1;
`ifdef ARM_COND_FULL_EN
         4'b0010: cond_pass_c = flag_c;
         4'b0011: cond_pass_c = ~flag_c;
         4'b0100: cond_pass_c = flag_n;
         4'b0101: cond_pass_c = ~flag_n;
         4'b0110: cond_pass_c = flag_v;
         4'b0111: cond_pass_c = ~flag_v;
         4'b1000: cond_pass_c = flag_c & ~flag_z;
         4'b1001: cond_pass_c = ~flag_c | flag_z;
         4'b1100: cond_pass_c = ~flag_z & (flag_n == flag_v);
         4'b1101: cond_pass_c = flag_z | (flag_n != flag_v);
`endif
         default: cond_pass_c = 1'b0;
      endcase
   end

   // CBZ/CBNZ run the ALU in pass-B mode, so alu_zero is the tested register's zero test.
   always_comb begin
      taken_c  = (is_bcond & cond_pass_c) | (is_cbz & alu_zero) | (is_cbnz & ~alu_zero);
      accept_c = ~flush & ~stall;
   end

   // Pipeline slot: flush squashes, stall holds everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_valid        <= 1'b0;
         mem_result       <= '0;
         mem_rd           <= '0;
         mem_reg_write    <= 1'b0;
         mem_branch_taken <= 1'b0;
      end else if (flush) begin
         mem_valid        <= 1'b0;
         mem_reg_write    <= 1'b0;
         mem_branch_taken <= 1'b0;
      end else if (!stall) begin
         mem_valid        <= ex_valid;
         mem_result       <= alu_out;
         mem_rd           <= rd;
         mem_reg_write    <= ex_valid & reg_write;
         mem_branch_taken <= ex_valid & taken_c;
      end
   end

   // Architectural NZCV, written only by accepted flag-setting instructions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flag_n <= 1'b0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else if (accept_c && ex_valid && set_flags) begin
         flag_n <= alu_negative;
         flag_z <= alu_zero;
         flag_c <= alu_carry;
         flag_v <= alu_overflow;
      end
   end

endmodule

// File: tb/tb_ex_flags_stage.sv
// Scoreboard bench for ex_flags_stage: driver pushes reference-model outputs per cycle,
// a monitor pops and compares after each rising edge.
module tb_ex_flags_stage;

   typedef struct packed {
      logic        rst;
      logic        ex_valid;
      logic        stall;
      logic        flush;
      logic [63:0] alu_out;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
      logic        set_flags;
      logic        is_bcond;
      logic        is_cbz;
      logic        is_cbnz;
      logic [3:0]  cond;
      logic [4:0]  rd;
      logic        reg_write;
   } stim_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] result;
      logic [4:0]  rd;
      logic        rw;
      logic        bt;
      logic        n;
      logic        z;
      logic        c;
      logic        v;
   } out_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, stall, flush;
   logic [63:0] alu_out;
   logic        alu_zero, alu_negative, alu_carry, alu_overflow;
   logic        set_flags, is_bcond, is_cbz, is_cbnz;
   logic [3:0]  cond;
   logic [4:0]  rd;
   logic        reg_write;
   logic        mem_valid;
   logic [63:0] mem_result;
   logic [4:0]  mem_rd;
   logic        mem_reg_write, mem_branch_taken;
   logic        flag_n, flag_z, flag_c, flag_v;

   int    checks = 0;
   int    errors = 0;
   out_t  model;
   out_t  exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   ex_flags_stage #(.DATA_W(64), .REG_W(5)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .stall(stall), .flush(flush),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow), .set_flags(set_flags),
      .is_bcond(is_bcond), .is_cbz(is_cbz), .is_cbnz(is_cbnz), .cond(cond), .rd(rd),
      .reg_write(reg_write), .mem_valid(mem_valid), .mem_result(mem_result),
      .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_branch_taken(mem_branch_taken),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
   );

   // ARM rule: cond[3:1] picks a test, cond[0] inverts it (except AL).
   function automatic logic cond_ok(input logic [3:0] cc, input logic n, z, c, v);
      logic r;
      case (cc[3:1])
         3'd0: r = z;
         3'd1: r = c;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = c & ~z;
         3'd5: r = (n == v);
         3'd6: r = ~z & (n == v);
         default: r = 1'b1;
      endcase
      if (cc[3:1] != 3'd7 && cc[0]) r = ~r;
`ifndef ARM_COND_FULL_EN
      if (!(cc[3:1] == 3'd0 || cc[3:1] == 3'd5 || cc[3:1] == 3'd7)) r = 1'b0;
`endif
      return r;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t alu_op(input logic [63:0] val, input logic n, z, c, v,
                                    input logic sf);
      stim_t s;
      s = '0;
      s.ex_valid = 1'b1;
      s.alu_out = val;
      s.n = n; s.z = z; s.c = c; s.v = v;
      s.set_flags = sf;
      s.rd = 5'd7;
      s.reg_write = 1'b1;
      return s;
   endfunction

   function automatic stim_t branch(input logic bc, cz, cnz, input logic [3:0] cc,
                                    input logic [63:0] val);
      stim_t s;
      s = '0;
      s.ex_valid = 1'b1;
      s.is_bcond = bc; s.is_cbz = cz; s.is_cbnz = cnz;
      s.cond = cc;
      s.alu_out = val;
      s.z = (val == 64'd0);
      s.rd = 5'd1;
      return s;
   endfunction

   // Drive one cycle, advance the model past the next rising edge and queue the expectation.
   task automatic step(input stim_t s, input string name);
      logic tk;
      reset = s.rst; ex_valid = s.ex_valid; stall = s.stall; flush = s.flush;
      alu_out = s.alu_out; alu_zero = s.z; alu_negative = s.n; alu_carry = s.c;
      alu_overflow = s.v; set_flags = s.set_flags; is_bcond = s.is_bcond;
      is_cbz = s.is_cbz; is_cbnz = s.is_cbnz; cond = s.cond; rd = s.rd;
      reg_write = s.reg_write;
      if (s.rst) begin
         model = '0;
      end else if (s.flush) begin
         model.valid = 1'b0;
         model.rw = 1'b0;
         model.bt = 1'b0;
      end else if (!s.stall) begin
         tk = (s.is_bcond && cond_ok(s.cond, model.n, model.z, model.c, model.v)) ||
              (s.is_cbz && s.z) || (s.is_cbnz && !s.z);
         model.valid = s.ex_valid;
         model.result = s.alu_out;
         model.rd = s.rd;
         model.rw = s.ex_valid & s.reg_write;
         model.bt = s.ex_valid & tk;
         if (s.ex_valid && s.set_flags) begin
            model.n = s.n; model.z = s.z; model.c = s.c; model.v = s.v;
         end
      end
      exp_q.push_back(model);
      name_q.push_back(name);
      @(negedge clk);
   endtask

   // Monitor: compare the registered outputs after every rising edge that has an expectation.
   initial begin
      out_t  got, exp;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm = name_q.pop_front();
            got = {mem_valid, mem_result, mem_rd, mem_reg_write, mem_branch_taken,
                   flag_n, flag_z, flag_c, flag_v};
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
         end
      end
   end

   initial begin
      stim_t s;
      int    wait_cycles;
      // Reset with random inputs, then idle.
      for (int i = 0; i < 2; i++) begin
         s = stim_t'({$urandom(), $urandom(), $urandom(), $urandom()});
         s.rst = 1'b1;
         step(s, "reset");
      end
      step(idle(), "idle_after_reset");
      step(idle(), "idle_after_reset");
      // SUBS 5-5 then B.EQ.
      step(alu_op(64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), "subs_flags");
      step(branch(1'b1, 1'b0, 1'b0, 4'b0000, 64'd5), "beq_taken");
      // N=1,V=0, then non-flag ADD with alu_zero=1, then LT/GE.
      step(alu_op(64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "set_n");
      step(alu_op(64'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0), "add_no_flags");
      step(branch(1'b1, 1'b0, 1'b0, 4'b1011, 64'd3), "blt_taken");
      step(branch(1'b1, 1'b0, 1'b0, 4'b1010, 64'd3), "bge_not_taken");
      // CBZ/CBNZ.
      step(branch(1'b0, 1'b1, 1'b0, 4'd0, 64'd0), "cbz_zero");
      step(branch(1'b0, 1'b0, 1'b1, 4'd0, 64'd1), "cbnz_one");
      step(branch(1'b0, 1'b0, 1'b1, 4'd0, 64'd0), "cbnz_zero");
      // Stall three cycles with a pending SUBS, then stall+flush.
      s = alu_op(64'h1234, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      s.stall = 1'b1;
      for (int i = 0; i < 3; i++) step(s, "stall_hold");
      s.flush = 1'b1;
      step(s, "stall_flush");
      // HI with C=1,Z=0.
      step(alu_op(64'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), "set_c");
      step(branch(1'b1, 1'b0, 1'b0, 4'b1000, 64'd2), "bhi");
      // Flag setter carrying a B.cond: old flags decide, new flags written.
      s = alu_op(64'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      s.is_bcond = 1'b1;
      s.cond = 4'b0000;
      step(s, "setflags_bcond");
      step(branch(1'b1, 1'b0, 1'b0, 4'b0000, 64'd2), "beq_after");
      // Reset in the middle of a stall.
      s = alu_op(64'd77, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      s.stall = 1'b1;
      step(s, "pre_stall");
      s.rst = 1'b1;
      step(s, "reset_mid_stall");
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         s = '0;
         s.rst = ($urandom_range(0, 49) == 0);
         s.ex_valid = ($urandom_range(0, 5) != 0);
         s.stall = ($urandom_range(0, 7) == 0);
         s.flush = ($urandom_range(0, 9) == 0);
         s.alu_out = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom(), $urandom()};
         s.z = (s.alu_out == 64'd0);
         s.n = s.alu_out[63];
         s.c = 1'($urandom());
         s.v = 1'($urandom());
         s.set_flags = 1'($urandom());
         case ($urandom_range(0, 3))
            0: s.is_bcond = 1'b1;
            1: s.is_cbz = 1'b1;
            2: s.is_cbnz = 1'b1;
            default: ;
         endcase
         s.cond = 4'($urandom());
         s.rd = 5'($urandom());
         s.reg_write = 1'($urandom());
         step(s, "random");
      end
      wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
